ram_streamer: RTL and testbench

Sequencing master for the single-port `ram` block. It either fills a contiguous address window from an incoming valid/ready word stream (load) or reads a window out as a valid/ready word stream (dump). It drives the RAM's `enable`/`address`/`data_in` pins and consumes its registered `data_out`. It sits between the RAM and any producer or consumer that must not handle addressing or the RAM's one-cycle read latency itself.

---
 rtl/ram_streamer_if.sv | 45 ++++
 rtl/ram_streamer.sv | 117 +++++++++++
 tb/tb_ram_streamer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ram_streamer_if.sv
// ram_streamer_if: bundles every non-clock/reset signal between ram_streamer,
// its command source, its load producer, its dump consumer and the RAM.
//   master modport : the streamer side (drives busy/done, stream outputs, RAM pins)
//   slave modport  : the environment side (commands, stream inputs, RAM data_out)
// Signals:
//   start/mode/base_addr/length : operation request, sampled in IDLE
//   busy/done                   : status
//   in_data/in_valid/in_ready   : load word stream
//   out_data/out_valid/out_ready: dump word stream
//   ram_enable/ram_address/ram_data_in/ram_data_out : single-port RAM pins
interface ram_streamer_if #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS    = 8
);
  logic                    start;
  logic                    mode;
  logic [ADDRESS_BITS-1:0] base_addr;
  logic [ADDRESS_BITS:0]   length;
  logic                    busy;
  logic                    done;
  logic [DATA_BITS-1:0]    in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_BITS-1:0]    out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    ram_enable;
  logic [ADDRESS_BITS-1:0] ram_address;
  logic [DATA_BITS-1:0]    ram_data_in;
  logic [DATA_BITS-1:0]    ram_data_out;

  modport master (
    input  start, mode, base_addr, length,
    input  in_data, in_valid, out_ready, ram_data_out,
    output busy, done, in_ready, out_data, out_valid,
    output ram_enable, ram_address, ram_data_in
  );

  modport slave (
    output start, mode, base_addr, length,
    output in_data, in_valid, out_ready, ram_data_out,
    input  busy, done, in_ready, out_data, out_valid,
    input  ram_enable, ram_address, ram_data_in
  );
endinterface

// File: rtl/ram_streamer.sv
// ram_streamer: sequencing master for a single-port RAM with registered
// data_out. A load fills a contiguous (wrapping) address window from a
// valid/ready word stream; a dump reads a window back out as a valid/ready
// stream, hiding the RAM's one-cycle read latency from the consumer.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, returns to IDLE
//   bus   : ram_streamer_if.master (command, status, both streams, RAM pins)
module ram_streamer #(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           reset,
  ram_streamer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DUMP_ADDR,
    S_DUMP_CAP,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  localparam logic [ADDRESS_BITS-1:0] ADDR_ONE = 1;
  localparam logic [ADDRESS_BITS:0]   REM_ONE  = 1;

  state_t                  r_state,     w_state_nxt;
  logic [ADDRESS_BITS-1:0] r_addr,      w_addr_nxt;
  logic [ADDRESS_BITS:0]   r_remaining, w_remaining_nxt;
  logic [DATA_BITS-1:0]    r_out_data,  w_out_data_nxt;
  logic                    r_out_valid, w_out_valid_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_remaining_nxt = r_remaining;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    bus.busy        = (r_state != S_IDLE);
    bus.done        = 1'b0;
    bus.in_ready    = 1'b0;
    bus.ram_enable  = 1'b0;
    // The address pins always follow addr; only LOAD drives write data.
    bus.ram_address = r_addr;
    bus.ram_data_in = '0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_addr_nxt      = bus.base_addr;
          w_remaining_nxt = bus.length;
          if (bus.length == '0)  w_state_nxt = S_DONE;
          else if (bus.mode)     w_state_nxt = S_DUMP_ADDR;
          else                   w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // in_ready is constant here, so the write strobe is just in_valid.
        bus.in_ready    = 1'b1;
        bus.ram_enable  = bus.in_valid;
        bus.ram_data_in = bus.in_data;
        if (bus.in_valid) begin
          w_addr_nxt      = r_addr + ADDR_ONE;
          w_remaining_nxt = r_remaining - REM_ONE;
          if (r_remaining == REM_ONE) w_state_nxt = S_DONE;
        end
      end
      S_DUMP_ADDR: begin
        w_state_nxt = S_DUMP_CAP;
      end
      S_DUMP_CAP: begin
        // RAM data_out now reflects the address presented last cycle.
        w_out_data_nxt  = bus.ram_data_out;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DUMP_OUT;
      end
      S_DUMP_OUT: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_addr_nxt      = r_addr + ADDR_ONE;
          w_remaining_nxt = r_remaining - REM_ONE;
          w_state_nxt     = (r_remaining == REM_ONE) ? S_DONE : S_DUMP_ADDR;
        end
      end
      S_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_ram_streamer.sv
module tb_ram_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   wr_count = 0;

  logic [7:0] mem     [64];
  logic [7:0] ref_mem [64];

  ram_streamer_if #(.ADDRESS_BITS(6), .DATA_BITS(8)) bus ();

  ram_streamer #(.ADDRESS_BITS(6), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: write on enable, registered read-first data_out.
  always @(posedge clk) begin
    if (bus.ram_enable) mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_address];
  end

  always @(posedge clk) begin
    if (bus.ram_enable) wr_count <= wr_count + 1;
  end

  typedef struct {
    bit m;
    int base;
    int len;
    bit rnd;
    int w0;
    int stall_w;
    bit inj;
    int abort_at;
    int exp_cyc;
  } op_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctl"}, {bus.busy, bus.done, bus.in_ready, bus.out_valid, bus.ram_enable}, 0);
    chk({nm, "_data"}, {bus.out_data, bus.ram_address, bus.ram_data_in}, 0);
  endtask

  // One complete operation; the expected behaviour comes from the window
  // rules (address = base + index mod 64, stream order, RAM contents model).
  task automatic run_op(input op_t op);
    logic [7:0] words[$];
    logic [7:0] cur_w;
    int widx = 0;
    int ridx = 0;
    int cyc = 0;
    int wr0;
    int stall_n = 0;
    bit fin = 0;
    bit inj_now;
    for (int i = 0; i < op.len; i++)
      words.push_back((op.w0 != 0) ? 8'(op.w0 + i) : 8'($urandom));
    wr0 = wr_count;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = op.m; bus.base_addr = 6'(op.base); bus.length = 7'(op.len);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; cyc = 1;
    chk("busy_rise", bus.busy, 1);
    while (!fin) begin
      inj_now = op.inj && (cyc == 2);
      bus.start     = inj_now;
      bus.base_addr = inj_now ? 6'(op.base + 20) : 6'(op.base);
      bus.length    = inj_now ? 7'(op.len + 3) : 7'(op.len);
      bus.mode      = op.m;
      if (bus.done) begin
        if (op.exp_cyc >= 0) chk("done_latency", cyc, op.exp_cyc);
        chk("words_done", op.m ? ridx : widx, op.len);
        chk("end_addr", bus.ram_address, (op.base + op.len) % 64);
        chk("write_count", wr_count - wr0, op.m ? 0 : op.len);
        @(negedge clk);
        chk("done_pulse", {bus.done, bus.busy}, 0);
        fin = 1;
      end else if (cyc > 1000) begin
        failures++;
        $display("FAIL timeout actual=%0d cycles required=done", cyc);
        fin = 1;
      end else if (!op.m) begin
        if (op.abort_at >= 0 && widx == op.abort_at) begin
          bus.in_valid = 1'b0;
          rst = 1'b1;
          #1;
          chk_reset_outs("abort");
          @(negedge clk);
          chk("abort_no_done", bus.done, 0);
          rst = 1'b0;
          chk("abort_writes", wr_count - wr0, op.abort_at);
          fin = 1;
        end else begin
          cur_w = (widx < op.len) ? words[widx] : 8'h00;
          bus.in_valid = op.rnd ? 1'($urandom) : 1'b1;
          bus.in_data  = cur_w;
          #1;
          chk("in_ready", bus.in_ready, 1);
          chk("load_port", {bus.ram_enable, bus.ram_address, bus.ram_data_in},
              {bus.in_valid, 6'(op.base + widx), cur_w});
          if (bus.in_valid && widx < op.len) begin
            ref_mem[(op.base + widx) % 64] = cur_w;
            widx++;
          end
          @(negedge clk);
          cyc++;
        end
      end else begin
        if (op.stall_w == ridx && bus.out_valid && stall_n < 5) begin
          bus.out_ready = 1'b0;
          stall_n++;
        end else begin
          bus.out_ready = op.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
        #1;
        chk("dump_port", {bus.ram_enable, bus.ram_address}, {1'b0, 6'(op.base + ridx)});
        if (bus.out_valid) begin
          chk("out_data", bus.out_data,
              (ridx < op.len) ? ref_mem[(op.base + ridx) % 64] : 8'h00);
          if (bus.out_ready) ridx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  op_t ops[14];
  op_t r;

  initial begin
    //         m  base len rnd  w0    stall inj abort exp
    ops[0]  = '{0, 2,   4,  0,  'hA1, -1,   0,  -1,   5};
    ops[1]  = '{1, 2,   4,  0,  0,    -1,   0,  -1,   13};
    ops[2]  = '{0, 62,  4,  0,  'hC1, -1,   0,  -1,   5};
    ops[3]  = '{1, 62,  4,  0,  0,    -1,   0,  -1,   13};
    ops[4]  = '{1, 2,   4,  0,  0,    1,    0,  -1,   18};
    ops[5]  = '{0, 0,   0,  0,  0,    -1,   0,  -1,   1};
    ops[6]  = '{1, 5,   0,  0,  0,    -1,   0,  -1,   1};
    ops[7]  = '{0, 10,  64, 0,  0,    -1,   0,  -1,   65};
    ops[8]  = '{1, 10,  64, 0,  0,    -1,   0,  -1,   193};
    ops[9]  = '{0, 20,  6,  1,  0,    -1,   0,  -1,   -1};
    ops[10] = '{1, 20,  6,  1,  0,    -1,   0,  -1,   -1};
    ops[11] = '{0, 30,  5,  0,  0,    -1,   1,  -1,   6};
    ops[12] = '{1, 30,  5,  0,  0,    -1,   1,  -1,   16};
    ops[13] = '{1, 2,   4,  0,  0,    -1,   0,  -1,   13};

    bus.start = 0; bus.mode = 0; bus.base_addr = 0; bus.length = 0;
    bus.in_data = 0; bus.in_valid = 0; bus.out_ready = 0;

    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("idle");

    for (int i = 0; i < 14; i++) run_op(ops[i]);

    // Randomized operations over the whole address space.
    for (int i = 0; i < 12; i++) begin
      r = '{1'($urandom), int'($urandom_range(0, 63)), int'($urandom_range(1, 12)),
            1'b1, 0, -1, 1'($urandom), -1, -1};
      run_op(r);
    end

    // Reset after 2 of 4 load writes, then read the window back.
    r = '{0, 40, 4, 0, 'hB1, -1, 0, 2, -1};
    run_op(r);
    r = '{1, 40, 4, 0, 0, -1, 0, -1, 13};
    run_op(r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
